trng_sample_ctrl: RTL

Sequencer for the ring-oscillator entropy cell.
- Enables the cell and waits for a warm-up period.
- Pulses the cell's output-sample enable at a fixed divided rate and assembles the returned raw bits into bytes.
- Runs a repetition-count health test on the raw bits.
- Delivers each byte over a valid/ready handshake to the pin mux or a host-readout block.

---
 rtl/trng_pkg.sv | 32 +++
 rtl/trng_sample_ctrl_health.sv | 55 +++++
 rtl/trng_sample_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// trng_pkg
// Shared definitions for the ring-oscillator sample controller: the
// sequencer state encoding, default parameter values, counter widths and
// a counter-width helper.
// No ports (package).

package trng_pkg;

    localparam int unsigned DEF_WARMUP_CYCLES = 64;
    localparam int unsigned DEF_SAMPLE_DIV    = 8;
    localparam int unsigned DEF_BYTE_W        = 8;
    localparam int unsigned DEF_REP_LIMIT     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        SAMPLE = 3'd2,
        HOLD   = 3'd3,
        FAIL   = 3'd4
    } trng_state_t;

    // Width of a counter that must hold the values 0..max_count-1.
    function automatic int unsigned cnt_w(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    localparam int unsigned DEF_CYC_W = $clog2(DEF_WARMUP_CYCLES);
    localparam int unsigned DEF_PER_W = $clog2(DEF_SAMPLE_DIV);
    localparam int unsigned DEF_BIT_W = $clog2(DEF_BYTE_W);
    localparam int unsigned DEF_RUN_W = $clog2(DEF_REP_LIMIT + 1);

endpackage

// File: rtl/trng_sample_ctrl_health.sv
// trng_health_rct
// Repetition-count health test on the raw entropy bit stream. Counts
// consecutive identical bits; the count restarts at 1 on a change.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   clear      clears the run count (sequencer idle)
//   bit_valid  a raw bit is presented this cycle
//   sample_bit the raw bit
//   fail       combinational: this bit makes the run reach REP_LIMIT

module trng_health_rct
    import trng_pkg::*;
#(
    parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_valid,
    input  logic sample_bit,
    output logic fail
);

    localparam int unsigned RUN_W = cnt_w(REP_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(REP_LIMIT);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             last_bit;

    always_comb begin
        run_next = RUN_W'(1);
        if (run_cnt != '0 && sample_bit == last_bit) begin
            // saturate so a held failure never wraps back to a short run
            run_next = (run_cnt == RUN_LIMIT) ? RUN_LIMIT : run_cnt + RUN_W'(1);
        end
    end

    assign fail = bit_valid && (run_next == RUN_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (clear) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (bit_valid) begin
            run_cnt  <= run_next;
            last_bit <= sample_bit;
        end
    end

endmodule

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl
// Sequencer for the ring-oscillator entropy cell: enables the cell, waits
// a warm-up period, strobes a sample every SAMPLE_DIV cycles, assembles raw
// bits MSB first into BYTE_W-bit words, runs a repetition-count health test
// and hands words out over a valid/ready handshake.
// Optional feature macro: TRNG_VON_NEUMANN_EN -- when defined, raw bits are
// debiased in pairs (01 -> 0, 10 -> 1, 00/11 dropped) before assembly.
// Ports:
//   clk          system clock (also the cell's sampling clock)
//   rst_n        synchronous active-low reset
//   start        level run enable
//   ent_bit      raw bit from the entropy cell
//   en_samp_in0  oscillator enable, leg 0
//   en_samp_in1  oscillator enable, leg 1
//   en_samp_out  one-cycle sample strobe to the cell
//   rnd_data     assembled random word
//   rnd_valid    rnd_data is valid
//   rnd_ready    consumer accepts the word
//   busy         sequencer not idle
//   health_fail  sticky health-test failure

module trng_sample_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int unsigned BYTE_W        = DEF_BYTE_W,
    parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ent_bit,
    output logic              en_samp_in0,
    output logic              en_samp_in1,
    output logic              en_samp_out,
    output logic [BYTE_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int unsigned CYC_W = cnt_w(WARMUP_CYCLES);
    localparam int unsigned PER_W = cnt_w(SAMPLE_DIV);
    localparam int unsigned BIT_W = cnt_w(BYTE_W);

    localparam logic [CYC_W-1:0] WARM_LAST = CYC_W'(WARMUP_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BYTE_W - 1);

    trng_state_t state, state_next;

    logic [CYC_W-1:0]  cyc_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] word_next;

    logic strobe;
    logic accept;
    logic acc_bit;
    logic byte_done;
    logic hit_fail;
    logic leave_run;
    logic xfer;

    assign strobe    = (state == SAMPLE) && (per_cnt == PER_LAST);
    assign byte_done = accept && (bit_cnt == BIT_LAST);
    assign word_next = {shreg[BYTE_W-2:0], acc_bit};
    assign xfer      = rnd_valid && rnd_ready;
    assign leave_run = !start &&
                       (state == WARMUP || state == SAMPLE || state == HOLD);

`ifdef TRNG_VON_NEUMANN_EN
    logic vn_have;
    logic vn_first;

    // A bit is emitted on the second of a pair when the two differ; the
    // emitted value equals the first bit of the pair.
    assign accept  = strobe && vn_have && (vn_first != ent_bit);
    assign acc_bit = vn_first;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (leave_run || hit_fail || state != SAMPLE) begin
            vn_have  <= 1'b0;
        end else if (strobe) begin
            if (vn_have) begin
                vn_have  <= 1'b0;
            end else begin
                vn_have  <= 1'b1;
                vn_first <= ent_bit;
            end
        end
    end
`else
    assign accept  = strobe;
    assign acc_bit = ent_bit;
`endif

    // Health test sees every raw strobed bit, including ones the debiaser drops.
    trng_health_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == IDLE),
        .bit_valid  (strobe),
        .sample_bit (ent_bit),
        .fail       (hit_fail)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = WARMUP;
            end
            WARMUP: begin
                if (!start)                    state_next = IDLE;
                else if (cyc_cnt == WARM_LAST) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (!start)         state_next = IDLE;
                else if (hit_fail)  state_next = FAIL;
                else if (byte_done) state_next = HOLD;
            end
            HOLD: begin
                if (!start)    state_next = IDLE;
                else if (xfer) state_next = SAMPLE;
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        en_samp_in0 = 1'b0;
        en_samp_in1 = 1'b0;
        en_samp_out = strobe;
        busy        = (state != IDLE);
        case (state)
            WARMUP, SAMPLE, HOLD: begin
                en_samp_in0 = 1'b1;
                en_samp_in1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, word assembly and handshake registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            per_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else if (leave_run) begin
            cyc_cnt   <= '0;
            per_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    per_cnt <= '0;
                end
                WARMUP: begin
                    cyc_cnt <= (cyc_cnt == WARM_LAST) ? '0 : cyc_cnt + CYC_W'(1);
                    per_cnt <= '0;
                end
                SAMPLE: begin
                    if (hit_fail) begin
                        // failure outranks a word completing on the same edge
                        health_fail <= 1'b1;
                        rnd_valid   <= 1'b0;
                        shreg       <= '0;
                        bit_cnt     <= '0;
                        per_cnt     <= '0;
                    end else begin
                        per_cnt <= strobe ? '0 : per_cnt + PER_W'(1);
                        if (accept) begin
                            if (byte_done) begin
                                rnd_data  <= word_next;
                                rnd_valid <= 1'b1;
                                shreg     <= '0;
                                bit_cnt   <= '0;
                            end else begin
                                shreg   <= word_next;
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    per_cnt <= '0;
                    if (xfer) rnd_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
